if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the ID decoder.
- Owns the fetch PC register and drives the synchronous instruction SRAM (read data returns one cycle after the address).
- Owns the IF/ID pipeline register that presents id_pc, id_inst, id_ce and the delay-slot flag to ID.
- Applies ID branch redirects from br_bus with MIPS delay-slot semantics, and handles stalls, exception/ERET flush, and instruction buffering while ID is held.

---
 rtl/if_stage_pkg.sv | 9 +
 rtl/if_pc_next.sv | 22 ++
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'hBFC0_0000;
    localparam int          DEF_BR_BUS_WD = 33;
    localparam int          IF_TO_ID_WD   = 65;
    localparam logic [31:0] EXC_VECTOR    = 32'hBFC0_0380;

endpackage

// File: rtl/if_pc_next.sv
// Next fetch PC selection: a deferred branch first, then a live branch, then sequential.
module if_pc_next
    import if_stage_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_br_pending,
    input  logic [31:0] i_br_target,
    input  logic        i_br_e,
    input  logic [31:0] i_br_addr,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_br_pending) begin
            o_next_pc = i_br_target;
        end else if (i_br_e) begin
            o_next_pc = i_br_addr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, instruction SRAM interface, IF/ID register,
// delay-slot branch redirect, stall handling and flush.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BR_BUS_WD = DEF_BR_BUS_WD
)
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stall_f,
    input  logic                 stall_d,
    input  logic                 flush,
    input  logic [31:0]          new_pc,
    input  logic [BR_BUS_WD-1:0] br_bus,
    input  logic                 id_is_branch,
    output logic                 inst_sram_en,
    output logic [3:0]           inst_sram_wen,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic [31:0]          inst_sram_rdata,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_inst,
    output logic                 id_ce,
    output logic                 id_in_delayslot
);

    logic        r_ce;
    logic [31:0] r_pc;
    logic        r_br_pending;
    logic [31:0] r_br_target;
    logic [31:0] r_id_pc;
    logic        r_id_ce;
    logic        r_id_ds;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    logic                   w_br_e;
    logic [31:0]            w_br_addr;
    logic                   w_advance;
    logic                   w_fetch_en;
    logic [31:0]            w_next_pc;
    logic [31:0]            w_id_inst;
    logic [IF_TO_ID_WD-1:0] w_if_to_id;

    assign w_br_e     = br_bus[BR_BUS_WD-1];
    assign w_br_addr  = br_bus[31:0];
    assign w_advance  = r_ce & ~stall_f & ~stall_d;
    assign w_fetch_en = r_ce & (r_pc[1:0] == 2'b00);

    if_pc_next u_pc_next (
        .i_pc         (r_pc),
        .i_br_pending (r_br_pending),
        .i_br_target  (r_br_target),
        .i_br_e       (w_br_e),
        .i_br_addr    (w_br_addr),
        .o_next_pc    (w_next_pc)
    );

    // A branch resolved while fetch is frozen is parked until the PC can move.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc         <= RESET_PC;
            r_ce         <= 1'b0;
            r_br_pending <= 1'b0;
            r_br_target  <= 32'd0;
        end else if (flush) begin
            r_pc         <= new_pc;
            r_ce         <= 1'b1;
            r_br_pending <= 1'b0;
        end else begin
            r_ce <= 1'b1;
            if (w_advance) begin
                r_pc         <= w_next_pc;
                r_br_pending <= 1'b0;
            end else if (!stall_d && w_br_e) begin
                r_br_pending <= 1'b1;
                r_br_target  <= w_br_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_id_pc <= 32'd0;
            r_id_ce <= 1'b0;
            r_id_ds <= 1'b0;
        end else if (!stall_d) begin
            if (!stall_f) begin
                r_id_pc <= r_pc;
                r_id_ce <= w_fetch_en;
                r_id_ds <= id_is_branch & r_id_ce;
            end else begin
                r_id_pc <= 32'd0;
                r_id_ce <= 1'b0;
                r_id_ds <= 1'b0;
            end
        end
    end

    // While ID is held the SRAM re-reads the held PC, so the ID word is captured once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'd0;
        end else if (flush || !stall_d) begin
            r_buf_valid <= 1'b0;
        end else if (!r_buf_valid && r_id_ce) begin
            r_buf_valid <= 1'b1;
            r_inst_buf  <= inst_sram_rdata;
        end
    end

    assign w_id_inst  = r_buf_valid ? r_inst_buf : (r_id_ce ? inst_sram_rdata : 32'd0);
    assign w_if_to_id = {r_id_pc, w_id_inst, r_id_ce};

    assign {id_pc, id_inst, id_ce} = w_if_to_id;
    assign id_in_delayslot = r_id_ds;
    assign inst_sram_en    = w_fetch_en;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'd0;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage with a behavioural synchronous instruction SRAM.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall_f, stall_d, flush, id_is_branch;
    logic [31:0] new_pc;
    logic [32:0] br_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] id_pc, id_inst;
    logic        id_ce, id_in_delayslot;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush           (flush),
        .new_pc          (new_pc),
        .br_bus          (br_bus),
        .id_is_branch    (id_is_branch),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_ce           (id_ce),
        .id_in_delayslot (id_in_delayslot)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: one distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0020) return 32'h2402_0005;
        return {8'hA5, a[23:0]};
    endfunction

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    end

    typedef struct packed {
        logic        sf, sd, fl;
        logic [31:0] npc;
        logic        be;
        logic [31:0] ba;
        logic        isb;
        logic [31:0] addr;
        logic        en;
        logic [31:0] ipc;
        logic        ice;
        logic        ids;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic sf, input logic sd, input logic fl,
                                input logic [31:0] npc, input logic be, input logic [31:0] ba,
                                input logic isb, input logic [31:0] addr, input logic en,
                                input logic [31:0] ipc, input logic ice, input logic ids);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.npc = npc; v.be = be; v.ba = ba; v.isb = isb;
        v.addr = addr; v.en = en; v.ipc = ipc; v.ice = ice; v.ids = ids;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic en,
                           input logic [31:0] ipc, input logic ice, input logic ids,
                           input logic [31:0] iinst);
        $display("[TB] %s addr=%h en=%b id_pc=%h id_ce=%b ds=%b inst=%h",
                 tag, inst_sram_addr, inst_sram_en, id_pc, id_ce, id_in_delayslot, id_inst);
        chk({tag, " addr"},  inst_sram_addr, addr);
        chk({tag, " en"},    {31'd0, inst_sram_en}, {31'd0, en});
        chk({tag, " id_pc"}, id_pc, ipc);
        chk({tag, " id_ce"}, {31'd0, id_ce}, {31'd0, ice});
        chk({tag, " ds"},    {31'd0, id_in_delayslot}, {31'd0, ids});
        chk({tag, " inst"},  id_inst, iinst);
    endtask

    localparam logic [31:0] B = 32'hBFC0_0000;

    initial begin
        //                sf sd fl npc        be ba          isb addr      en ipc       ice ds
        vecs[0]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h000, 1, B+'h000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h004, 1, B+'h000, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h008, 1, B+'h004, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h00C, 1, B+'h008, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h010, 1, B+'h00C, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h014, 1, B+'h010, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0,           1, B+'h100,     1, B+'h100, 1, B+'h014, 1, 1);
        vecs[7]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h104, 1, B+'h100, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0,           1, B+'h018,     1, B+'h018, 1, B+'h104, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0,           0, 0,           0, B+'h01C, 1, B+'h018, 1, 0);
        vecs[10] = mk(0, 0, 0, 0,           0, 0,           0, B+'h020, 1, B+'h01C, 1, 0);
        vecs[11] = mk(0, 0, 0, 0,           0, 0,           0, B+'h024, 1, B+'h020, 1, 0);
        vecs[12] = mk(0, 1, 0, 0,           0, 0,           0, B+'h024, 1, B+'h020, 1, 0);
        vecs[13] = mk(1, 1, 0, 0,           0, 0,           0, B+'h024, 1, B+'h020, 1, 0);
        vecs[14] = mk(0, 1, 0, 0,           1, B+'h700,     0, B+'h024, 1, B+'h020, 1, 0);
        vecs[15] = mk(0, 0, 0, 0,           0, 0,           0, B+'h028, 1, B+'h024, 1, 0);
        vecs[16] = mk(0, 0, 0, 0,           0, 0,           0, B+'h02C, 1, B+'h028, 1, 0);
        vecs[17] = mk(0, 0, 0, 0,           0, 0,           0, B+'h030, 1, B+'h02C, 1, 0);
        vecs[18] = mk(0, 0, 0, 0,           0, 0,           0, B+'h034, 1, B+'h030, 1, 0);
        vecs[19] = mk(1, 0, 0, 0,           1, B+'h200,     1, B+'h034, 1, 32'd0,   0, 0);
        vecs[20] = mk(1, 0, 0, 0,           0, 0,           0, B+'h034, 1, 32'd0,   0, 0);
        vecs[21] = mk(0, 0, 0, 0,           0, 0,           0, B+'h200, 1, B+'h034, 1, 0);
        vecs[22] = mk(0, 0, 0, 0,           0, 0,           0, B+'h204, 1, B+'h200, 1, 0);
        vecs[23] = mk(1, 0, 0, 0,           1, B+'h300,     1, B+'h204, 1, 32'd0,   0, 0);
        vecs[24] = mk(0, 1, 0, 0,           0, 0,           0, B+'h204, 1, 32'd0,   0, 0);
        vecs[25] = mk(0, 1, 1, EXC_VECTOR,  0, 0,           0, B+'h380, 1, 32'd0,   0, 0);
        vecs[26] = mk(0, 0, 0, 0,           0, 0,           0, B+'h384, 1, B+'h380, 1, 0);
        vecs[27] = mk(0, 0, 0, 0,           0, 0,           0, B+'h388, 1, B+'h384, 1, 0);
        vecs[28] = mk(0, 1, 0, 0,           0, 0,           0, B+'h388, 1, B+'h384, 1, 0);
        vecs[29] = mk(0, 1, 1, B+'h500,     0, 0,           0, B+'h500, 1, 32'd0,   0, 0);
        vecs[30] = mk(0, 0, 0, 0,           0, 0,           0, B+'h504, 1, B+'h500, 1, 0);
        vecs[31] = mk(0, 0, 0, 0,           1, B+'h102,     1, B+'h102, 0, B+'h504, 1, 1);
        vecs[32] = mk(0, 0, 0, 0,           0, 0,           0, B+'h106, 0, B+'h102, 0, 0);
        vecs[33] = mk(0, 0, 0, 0,           0, 0,           0, B+'h10A, 0, B+'h106, 0, 0);

        resetn = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush = 1'b0;
        new_pc = 32'd0; br_bus = 33'd0; id_is_branch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", B, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wen", {28'd0, inst_sram_wen}, 32'd0);
        chk("wdata", inst_sram_wdata, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall_f      = vecs[i].sf;
            stall_d      = vecs[i].sd;
            flush        = vecs[i].fl;
            new_pc       = vecs[i].npc;
            br_bus       = {vecs[i].be, vecs[i].ba};
            id_is_branch = vecs[i].isb;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].ipc,
                    vecs[i].ice, vecs[i].ids, vecs[i].ice ? mem_word(vecs[i].ipc) : 32'd0);
        end

        // Mid-run reset, then release: fetch restarts at the reset vector.
        stall_f = 1'b0; stall_d = 1'b0; flush = 1'b0; br_bus = 33'd0; id_is_branch = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk_all("midreset", B, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rel0", B, 1'b1, B, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk_all("rel1", B+'h004, 1'b1, B, 1'b1, 1'b0, mem_word(B));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
